// File: rtl/sipo_frame_pkg.sv
// Shared types and constants for the framed serial receiver.
// Optional feature macro: SIPO_FRAME_PARITY_EN (even parity bit after the data bits).
package sipo_frame_pkg;

   localparam int STATE_W        = 2;
   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/sipo_shift_en.sv
// Serial-in/parallel-out shift register: din enters at the MSB and bits move toward the LSB,
// so after DATA_W shifts the first bit received sits in q[0].
module sipo_shift_en #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              en,
   input  logic              din,
   output logic [DATA_W-1:0] q
);

   // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         q <= '0;
      end else if (en) begin
         q <= {din, q[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, DATA_W data bits LSB first, [parity], stop bit, valid/ready output.
// Optional feature macro: SIPO_FRAME_PARITY_EN adds a PAR state checking even parity.
module sipo_frame_ctrl
   import sipo_frame_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   state_t             state;
   state_t             next;
   logic [CNT_W-1:0]   cnt;
   logic               start;
   logic               shift_en;
   logic               last_bit;
   logic               frame_ok;
   logic [DATA_W-1:0]  word;
`ifdef SIPO_FRAME_PARITY_EN
   logic               parity_acc;
`endif

   // Clearing on start-bit detection keeps the shifter free of stale bits from an abandoned frame.
   sipo_shift_en #(.DATA_W(DATA_W)) u_shift (
      .clk   (clk),
      .clr_n (rst_n && !start),
      .en    (shift_en),
      .din   (din),
      .q     (word)
   );

   assign last_bit = (cnt == CNT_W'(DATA_W - 1));
   assign busy     = (state != IDLE);

`ifdef SIPO_FRAME_PARITY_EN
   assign frame_ok = din && !parity_acc;
`else
   assign frame_ok = din;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      next     = state;
      start    = 1'b0;
      shift_en = 1'b0;
      case (state)
         IDLE: begin
            if (!din) begin
               next  = SHIFT;
               start = 1'b1;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last_bit) begin
`ifdef SIPO_FRAME_PARITY_EN
               next = PAR;
`else
               next = STOP;
`endif
            end
         end
`ifdef SIPO_FRAME_PARITY_EN
         PAR:     next = STOP;
`endif
         STOP:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
         parity_acc <= 1'b0;
`endif
      end else begin
         state     <= next;
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         if (start) begin
            cnt <= '0;
         end else if (shift_en) begin
            cnt <= cnt + 1'b1;
         end

`ifdef SIPO_FRAME_PARITY_EN
         if (start) begin
            parity_acc <= 1'b0;
         end else if (shift_en || state == PAR) begin
            parity_acc <= parity_acc ^ din;
         end
`endif

         if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end

         // A new word may load in the same cycle the held word is accepted.
         if (state == STOP) begin
            if (!frame_ok) begin
               frame_err <= 1'b1;
            end else if (!dout_valid || dout_ready) begin
               dout       <= word;
               dout_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule
